// File: rtl/spi_boot_loader_pkg.sv
// rtl/spi_boot_loader_pkg.sv - shared state enums and address constants for the SPI boot loader
package spi_boot_loader_pkg;

    localparam int RAM_AW = 18;

    localparam logic [RAM_AW-1:0] DEFAULT_BOOT_START_ADDR = 18'h0C000;
    localparam logic [RAM_AW-1:0] DEFAULT_BOOT_END_ADDR   = 18'h0FFFF;

    typedef enum logic [1:0] {
        WAIT,
        LOAD,
        FLUSH,
        DONE
    } top_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } write_state_t;

endpackage

// File: rtl/spi_boot_loader_sync_rx.sv
// rtl/spi_boot_loader_sync_rx.sv - SPI slave receiver: 2-flop synchronizers, edge detect, byte assembly
module spi_sync_rx (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       arm_ss,
    input  logic       arm_sclk,
    input  logic       arm_mosi,
    output logic       ss_fall,
    output logic       ss_rise,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic [1:0] ss_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       ss_q;
    logic       sclk_q;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       ss_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       sclk_rise;

    assign ss_s      = ss_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ss_fall   = ss_q & ~ss_s;
    assign ss_rise   = ~ss_q & ss_s;
    assign sclk_rise = ~sclk_q & sclk_s;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ss_sync    <= 2'b11;
            sclk_sync  <= 2'b11;
            mosi_sync  <= 2'b11;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b1;
            shift      <= 7'd0;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
        end else begin
            ss_sync    <= {ss_sync[0], arm_ss};
            sclk_sync  <= {sclk_sync[0], arm_sclk};
            mosi_sync  <= {mosi_sync[0], arm_mosi};
            ss_q       <= ss_s;
            sclk_q     <= sclk_s;
            byte_valid <= 1'b0;
            // mosi shares the synchronizer latency of sclk, so it is aligned at the rising edge
            if (ss_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s};
                end
            end
        end
    end

endmodule

// File: rtl/spi_boot_loader.sv
// rtl/spi_boot_loader.sv - loads an SPI-streamed boot image into external RAM; BOOT_CHECKSUM_EN adds a byte checksum port
module spi_boot_loader
    import spi_boot_loader_pkg::*;
#(
    parameter logic [RAM_AW-1:0] BOOT_START_ADDR = DEFAULT_BOOT_START_ADDR,
    parameter logic [RAM_AW-1:0] BOOT_END_ADDR   = DEFAULT_BOOT_END_ADDR,
    parameter int                WE_CYCLES       = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              arm_ss,
    input  logic              arm_sclk,
    input  logic              arm_mosi,
    output logic              booting,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_cs_b,
    output logic              ram_we_b,
    output logic              overflow
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

    top_state_t   state;
    write_state_t wstate;
    logic         ss_fall;
    logic         ss_rise;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic [7:0]   buffer;
    logic         pending;
    logic         full;
    logic [3:0]   we_cnt;
    logic         byte_accept;
    logic         take;

    spi_sync_rx u_rx (
        .clk        (clk),
        .reset_b    (reset_b),
        .arm_ss     (arm_ss),
        .arm_sclk   (arm_sclk),
        .arm_mosi   (arm_mosi),
        .ss_fall    (ss_fall),
        .ss_rise    (ss_rise),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // A byte can still land just after ss rises, so FLUSH accepts it too
    assign byte_accept = byte_valid && (state == LOAD || state == FLUSH);
    assign take        = (wstate == W_IDLE) && pending && !full;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= WAIT;
            booting <= 1'b1;
        end else begin
            case (state)
                WAIT:  if (ss_fall) state <= LOAD;
                LOAD:  if (ss_rise) state <= FLUSH;
                FLUSH: begin
                    if (wstate == W_IDLE && !pending && !byte_accept) begin
                        state   <= DONE;
                        booting <= 1'b0;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wstate   <= W_IDLE;
            pending  <= 1'b0;
            buffer   <= 8'd0;
            full     <= 1'b0;
            overflow <= 1'b0;
            we_cnt   <= 4'd0;
            ram_addr <= BOOT_START_ADDR;
            ram_dout <= 8'd0;
            ram_cs_b <= 1'b1;
            ram_we_b <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            checksum <= 16'd0;
`endif
        end else begin
            // When take and a new byte coincide, the old byte moves to ram_dout this cycle
            if (byte_accept) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    buffer  <= byte_data;
                    pending <= 1'b1;
                    if (pending && !take) overflow <= 1'b1;
                end
            end else if (take) begin
                pending <= 1'b0;
            end

            if (wstate == W_IDLE && pending && full) begin
                pending  <= 1'b0;
                overflow <= 1'b1;
            end

            case (wstate)
                W_IDLE: begin
                    if (take) begin
                        wstate   <= W_SETUP;
                        ram_dout <= buffer;
                        ram_cs_b <= 1'b0;
                        ram_we_b <= 1'b1;
                    end
                end
                W_SETUP: begin
                    wstate   <= W_STROBE;
                    ram_we_b <= 1'b0;
                    we_cnt   <= WE_LOAD;
                end
                W_STROBE: begin
                    if (we_cnt == 4'd0) begin
                        wstate   <= W_HOLD;
                        ram_we_b <= 1'b1;
                    end else begin
                        we_cnt <= we_cnt - 4'd1;
                    end
                end
                W_HOLD: begin
                    wstate   <= W_IDLE;
                    ram_cs_b <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    checksum <= checksum + {8'h00, ram_dout};
`endif
                    if (ram_addr == BOOT_END_ADDR) full <= 1'b1;
                    else                           ram_addr <= ram_addr + 18'd1;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule
